// File: rtl/fu_ls_unit.sv
// fu_ls_unit: blocking load/store functional unit between the LS reservation
// station, a single-outstanding req/gnt/rvalid data-memory port and the ROB
// completion broadcast.
// Optional feature macro: FU_LS_ALIGN_CHECK_EN (reject addresses not 8-byte aligned).

`ifndef GPR_SIZE
`define GPR_SIZE [63:0]
`endif
`ifndef ROB_IDX_SIZE
`define ROB_IDX_SIZE [4:0]
`endif

package fu_ls_pkg;
  typedef enum logic [3:0] {
    FU_OP_NOP  = 4'd0,
    FU_OP_ADD  = 4'd1,
    FU_OP_SUB  = 4'd2,
    FU_OP_AND  = 4'd3,
    FU_OP_ORR  = 4'd4,
    FU_OP_LDUR = 4'd5,
    FU_OP_STUR = 4'd6,
    FU_OP_B    = 4'd7
  } fu_op_t;
endpackage

module fu_ls_unit
  import fu_ls_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic                 in_clk,
  input  logic                 in_rst_n,
  input  logic                 in_rs_start,
  input  fu_op_t               in_rs_op,
  input  logic `GPR_SIZE       in_rs_val_a,
  input  logic `GPR_SIZE       in_rs_val_b,
  input  logic `ROB_IDX_SIZE   in_rs_dst_rob_index,
  output logic                 out_rs_ready,
  output logic                 out_mem_req,
  output logic                 out_mem_we,
  output logic `GPR_SIZE       out_mem_addr,
  output logic `GPR_SIZE       out_mem_wdata,
  input  logic                 in_mem_gnt,
  input  logic                 in_mem_rvalid,
  input  logic `GPR_SIZE       in_mem_rdata,
  output logic                 out_rob_done,
  output logic `ROB_IDX_SIZE   out_rob_dst_rob_index,
  output logic `GPR_SIZE       out_rob_value,
  output logic                 out_rob_error
);

  localparam int unsigned CW1 = CNT_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic `ROB_IDX_SIZE     dst_q, dst_d;
  logic `GPR_SIZE         val_q, val_d;
  logic                   err_q, err_d;

  logic                   rs_ready_d, mem_req_d, mem_we_d, rob_done_d, rob_error_d;
  logic `GPR_SIZE         mem_addr_d, mem_wdata_d, rob_value_d;
  logic `ROB_IDX_SIZE     rob_idx_d;

  logic                   is_ls;
  logic                   misaligned;
  logic                   timeout_hit;

  // Decode of the incoming entry and the timeout condition
  always_comb begin
    is_ls = (in_rs_op == FU_OP_LDUR) || (in_rs_op == FU_OP_STUR);
`ifdef FU_LS_ALIGN_CHECK_EN
    misaligned = |in_rs_val_a[2:0];
`else
    misaligned = 1'b0;
`endif
    // Fires on the cycle whose increment reaches TIMEOUT_CYCLES
    timeout_hit = (TIMEOUT_CYCLES != 0) &&
                  ((CW1'(cnt_q) + CW1'(1)) == CW1'(TIMEOUT_CYCLES));
  end

  // Next-state, datapath and registered-output next values
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dst_d       = dst_q;
    val_d       = val_q;
    err_d       = err_q;
    mem_we_d    = out_mem_we;
    mem_addr_d  = out_mem_addr;
    mem_wdata_d = out_mem_wdata;

    case (state_q)
      IDLE: begin
        if (in_rs_start) begin
          dst_d       = in_rs_dst_rob_index;
          cnt_d       = '0;
          val_d       = '0;
          mem_we_d    = (in_rs_op == FU_OP_STUR);
          mem_addr_d  = in_rs_val_a;
          mem_wdata_d = in_rs_val_b;
          if (is_ls && !misaligned) begin
            state_d = REQ;
            err_d   = 1'b0;
          end else begin
            state_d = RESP;
            err_d   = 1'b1;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (in_mem_gnt) begin
          state_d = out_mem_we ? RESP : WAIT;
          err_d   = 1'b0;
        end else if (timeout_hit) begin
          state_d = RESP;
          err_d   = 1'b1;
          val_d   = '0;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (in_mem_rvalid) begin
          state_d = RESP;
          err_d   = 1'b0;
          val_d   = in_mem_rdata;
        end else if (timeout_hit) begin
          state_d = RESP;
          err_d   = 1'b1;
          val_d   = '0;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Memory payload is only presented while a request is pending
    if (state_d != REQ) begin
      mem_we_d    = 1'b0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
    end

    rs_ready_d  = (state_d == IDLE);
    mem_req_d   = (state_d == REQ);
    rob_done_d  = (state_d == RESP);
    rob_idx_d   = rob_done_d ? dst_d : '0;
    rob_value_d = rob_done_d ? val_d : '0;
    rob_error_d = rob_done_d ? err_d : 1'b0;
  end

  // State, datapath and output registers
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q               <= IDLE;
      cnt_q                 <= '0;
      dst_q                 <= '0;
      val_q                 <= '0;
      err_q                 <= 1'b0;
      out_rs_ready          <= 1'b1;
      out_mem_req           <= 1'b0;
      out_mem_we            <= 1'b0;
      out_mem_addr          <= '0;
      out_mem_wdata         <= '0;
      out_rob_done          <= 1'b0;
      out_rob_dst_rob_index <= '0;
      out_rob_value         <= '0;
      out_rob_error         <= 1'b0;
    end else begin
      state_q               <= state_d;
      cnt_q                 <= cnt_d;
      dst_q                 <= dst_d;
      val_q                 <= val_d;
      err_q                 <= err_d;
      out_rs_ready          <= rs_ready_d;
      out_mem_req           <= mem_req_d;
      out_mem_we            <= mem_we_d;
      out_mem_addr          <= mem_addr_d;
      out_mem_wdata         <= mem_wdata_d;
      out_rob_done          <= rob_done_d;
      out_rob_dst_rob_index <= rob_idx_d;
      out_rob_value         <= rob_value_d;
      out_rob_error         <= rob_error_d;
    end
  end

endmodule

// File: tb/tb_fu_ls_unit.sv
// Directed bench for fu_ls_unit with TIMEOUT_CYCLES = 10.

`ifndef GPR_SIZE
`define GPR_SIZE [63:0]
`endif
`ifndef ROB_IDX_SIZE
`define ROB_IDX_SIZE [4:0]
`endif

module tb_fu_ls_unit;
  import fu_ls_pkg::*;

  logic               clk;
  logic               rst_n;
  logic               rs_start;
  fu_op_t             rs_op;
  logic `GPR_SIZE     rs_val_a;
  logic `GPR_SIZE     rs_val_b;
  logic `ROB_IDX_SIZE rs_dst;
  logic               rs_ready;
  logic               mem_req;
  logic               mem_we;
  logic `GPR_SIZE     mem_addr;
  logic `GPR_SIZE     mem_wdata;
  logic               mem_gnt;
  logic               mem_rvalid;
  logic `GPR_SIZE     mem_rdata;
  logic               rob_done;
  logic `ROB_IDX_SIZE rob_idx;
  logic `GPR_SIZE     rob_value;
  logic               rob_error;

  int checks = 0;
  int errors = 0;

  fu_ls_unit #(.TIMEOUT_CYCLES(10), .CNT_WIDTH(8)) dut (
    .in_clk                (clk),
    .in_rst_n              (rst_n),
    .in_rs_start           (rs_start),
    .in_rs_op              (rs_op),
    .in_rs_val_a           (rs_val_a),
    .in_rs_val_b           (rs_val_b),
    .in_rs_dst_rob_index   (rs_dst),
    .out_rs_ready          (rs_ready),
    .out_mem_req           (mem_req),
    .out_mem_we            (mem_we),
    .out_mem_addr          (mem_addr),
    .out_mem_wdata         (mem_wdata),
    .in_mem_gnt            (mem_gnt),
    .in_mem_rvalid         (mem_rvalid),
    .in_mem_rdata          (mem_rdata),
    .out_rob_done          (rob_done),
    .out_rob_dst_rob_index (rob_idx),
    .out_rob_value         (rob_value),
    .out_rob_error         (rob_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_entry(input fu_op_t op, input logic [63:0] a, input logic [63:0] b,
                             input logic [4:0] dst);
    rs_start = 1'b1;
    rs_op    = op;
    rs_val_a = a;
    rs_val_b = b;
    rs_dst   = dst;
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    rs_start   = 1'b0;
    rs_op      = FU_OP_NOP;
    rs_val_a   = '0;
    rs_val_b   = '0;
    rs_dst     = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;

    // Reset state
    #12;
    check("rst_ready", 64'(rs_ready), 64'd1);
    check("rst_req",   64'(mem_req),  64'd0);
    check("rst_done",  64'(rob_done), 64'd0);
    check("rst_addr",  64'(mem_addr), 64'd0);
    rst_n = 1'b1;
    tick();

    // Load: gnt in cycle 1, rvalid in cycle 2, done in cycle 3
    start_entry(FU_OP_LDUR, 64'h40, 64'h0, 5'd5);
    tick();
    rs_start = 1'b0;
    check("ld_c1_req",   64'(mem_req),  64'd1);
    check("ld_c1_we",    64'(mem_we),   64'd0);
    check("ld_c1_addr",  64'(mem_addr), 64'h40);
    check("ld_c1_ready", 64'(rs_ready), 64'd0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("ld_c2_req",  64'(mem_req),  64'd0);
    check("ld_c2_done", 64'(rob_done), 64'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h1234;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    check("ld_c3_done",  64'(rob_done),  64'd1);
    check("ld_c3_idx",   64'(rob_idx),   64'd5);
    check("ld_c3_value", 64'(rob_value), 64'h1234);
    check("ld_c3_err",   64'(rob_error), 64'd0);
    tick();
    check("ld_c4_done",  64'(rob_done), 64'd0);
    check("ld_c4_ready", 64'(rs_ready), 64'd1);

    // Store with grant withheld for 4 cycles
    start_entry(FU_OP_STUR, 64'h80, 64'hDEAD, 5'd7);
    tick();
    rs_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("st_stall_req",   64'(mem_req),   64'd1);
      check("st_stall_we",    64'(mem_we),    64'd1);
      check("st_stall_addr",  64'(mem_addr),  64'h80);
      check("st_stall_wdata", 64'(mem_wdata), 64'hDEAD);
      check("st_stall_done",  64'(rob_done),  64'd0);
      tick();
    end
    mem_gnt = 1'b1;
    check("st_gnt_req", 64'(mem_req), 64'd1);
    tick();
    mem_gnt = 1'b0;
    check("st_done",  64'(rob_done),  64'd1);
    check("st_idx",   64'(rob_idx),   64'd7);
    check("st_value", 64'(rob_value), 64'd0);
    check("st_err",   64'(rob_error), 64'd0);
    check("st_req",   64'(mem_req),   64'd0);
    tick();

    // Store with immediate grant: done in cycle 2, ready again in cycle 3
    start_entry(FU_OP_STUR, 64'h88, 64'h55, 5'd2);
    tick();
    rs_start = 1'b0;
    mem_gnt  = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("st2_c2_done",  64'(rob_done), 64'd1);
    check("st2_c2_ready", 64'(rs_ready), 64'd0);
    tick();
    check("st2_c3_ready", 64'(rs_ready), 64'd1);

    // Timeout: never granted, done with error in cycle 11; extra start ignored
    start_entry(FU_OP_LDUR, 64'h100, 64'h0, 5'd9);
    tick();
    rs_start = 1'b1;
    rs_dst   = 5'd12;
    for (int c = 1; c <= 10; c++) begin
      check("to_wait_done", 64'(rob_done), 64'd0);
      check("to_wait_req",  64'(mem_req),  64'd1);
      if (c == 10) rs_start = 1'b0;
      tick();
    end
    check("to_done",  64'(rob_done),  64'd1);
    check("to_err",   64'(rob_error), 64'd1);
    check("to_value", 64'(rob_value), 64'd0);
    check("to_idx",   64'(rob_idx),   64'd9);
    check("to_req",   64'(mem_req),   64'd0);
    tick();
    check("to_ready", 64'(rs_ready), 64'd1);
    tick();
    check("to_no_req", 64'(mem_req), 64'd0);

    // Misaligned load
    start_entry(FU_OP_LDUR, 64'h43, 64'h0, 5'd3);
    tick();
    rs_start = 1'b0;
`ifdef FU_LS_ALIGN_CHECK_EN
    check("mis_req",  64'(mem_req),   64'd0);
    check("mis_done", 64'(rob_done),  64'd1);
    check("mis_err",  64'(rob_error), 64'd1);
    tick();
    check("mis_req2", 64'(mem_req), 64'd0);
`else
    check("mis_req",  64'(mem_req),  64'd1);
    check("mis_addr", 64'(mem_addr), 64'h43);
    mem_gnt = 1'b1;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h77;
    tick();
    mem_rvalid = 1'b0;
    check("mis_done",  64'(rob_done),  64'd1);
    check("mis_err",   64'(rob_error), 64'd0);
    check("mis_value", 64'(rob_value), 64'h77);
    tick();
`endif

    // Illegal op: error done in cycle 1, no memory request
    start_entry(FU_OP_ADD, 64'h10, 64'h0, 5'd4);
    tick();
    rs_start = 1'b0;
    check("ill_done",  64'(rob_done),  64'd1);
    check("ill_err",   64'(rob_error), 64'd1);
    check("ill_value", 64'(rob_value), 64'd0);
    check("ill_idx",   64'(rob_idx),   64'd4);
    check("ill_req",   64'(mem_req),   64'd0);
    tick();

    // Stray rvalid in IDLE produces no completion
    mem_rvalid = 1'b1;
    mem_rdata  = 64'hBAD;
    tick();
    check("stray_done1", 64'(rob_done), 64'd0);
    tick();
    mem_rvalid = 1'b0;
    check("stray_done2", 64'(rob_done), 64'd0);
    check("stray_ready", 64'(rs_ready), 64'd1);

    // Reset asserted mid-WAIT
    start_entry(FU_OP_LDUR, 64'h200, 64'h0, 5'd6);
    tick();
    rs_start = 1'b0;
    mem_gnt  = 1'b1;
    tick();
    mem_gnt = 1'b0;
    rst_n   = 1'b0;
    #1;
    check("rw_done",  64'(rob_done), 64'd0);
    check("rw_req",   64'(mem_req),  64'd0);
    check("rw_ready", 64'(rs_ready), 64'd1);
    #2;
    rst_n = 1'b1;
    tick();

    // Load after reset completes normally
    start_entry(FU_OP_LDUR, 64'h48, 64'h0, 5'd11);
    tick();
    rs_start = 1'b0;
    check("pr_req", 64'(mem_req), 64'd1);
    mem_gnt = 1'b1;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'hCAFE;
    tick();
    mem_rvalid = 1'b0;
    check("pr_done",  64'(rob_done),  64'd1);
    check("pr_idx",   64'(rob_idx),   64'd11);
    check("pr_value", 64'(rob_value), 64'hCAFE);
    check("pr_err",   64'(rob_error), 64'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fu_ls_unit.md
# fu_ls_unit

Load/store functional unit sitting directly downstream of the LS reservation station. It accepts one ready LDUR/STUR entry at a time via the start/ready handshake and drives a single-outstanding request/grant/response data-memory port. It reports completion to the ROB as a one-cycle broadcast carrying the destination ROB index, the load data and an error flag. It is blocking: a new entry is accepted only after the previous one has been broadcast.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255, max cycles spent in REQ+WAIT before forced error completion; 0 disables the timeout.
- CNT_WIDTH, 8, timeout counter width; must satisfy TIMEOUT_CYCLES < 2**CNT_WIDTH.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- in_clk  input  1  clock, rising edge.
- in_rst_n  input  1  asynchronous, active-low reset.
- in_rs_start  input  1  RS presents a ready entry.
- in_rs_op  input  fu_op_t  FU_OP_LDUR or FU_OP_STUR.
- in_rs_val_a  input  `GPR_SIZE  effective address; RS has already added base and offset.
- in_rs_val_b  input  `GPR_SIZE  store data.
- in_rs_dst_rob_index  input  `ROB_IDX_SIZE  destination ROB entry.
- out_rs_ready  output  1  unit idle, can accept.
- out_mem_req  output  1  memory request valid.
- out_mem_we  output  1  1 = store, 0 = load.
- out_mem_addr  output  `GPR_SIZE  request address.
- out_mem_wdata  output  `GPR_SIZE  store data.
- in_mem_gnt  input  1  request accepted this cycle.
- in_mem_rvalid  input  1  load data valid.
- in_mem_rdata  input  `GPR_SIZE  load data.
- out_rob_done  output  1  completion broadcast, one-cycle pulse.
- out_rob_dst_rob_index  output  `ROB_IDX_SIZE  completing ROB entry.
- out_rob_value  output  `GPR_SIZE  load data; 0 for stores and for errors.
- out_rob_error  output  1  access fault, timeout or illegal op.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- **IDLE**
  - out_rs_ready = 1.
  - On in_rs_start: latch op, address, store data and dst index, clear the counter.
  - If op is FU_OP_LDUR or FU_OP_STUR, go to REQ. Otherwise go to RESP with error = 1.
- **REQ**
  - out_mem_req = 1. out_mem_addr, out_mem_wdata and out_mem_we come from the latched values and are held stable until grant.
  - On in_mem_gnt: a store goes to RESP; a load goes to WAIT.
- **WAIT**
  - On in_mem_rvalid: latch in_mem_rdata and go to RESP.
- **RESP**
  - out_rob_done = 1 for exactly one cycle, with the latched index, value and error. Then go to IDLE.
- **Timeout**
  - The counter increments each cycle in REQ or WAIT.
  - When it equals TIMEOUT_CYCLES (and TIMEOUT_CYCLES ≠ 0), go to RESP with error = 1 and value = 0. out_mem_req drops immediately.
- **Ignored inputs**
  - in_mem_rvalid is ignored in IDLE, REQ and RESP.
  - in_mem_gnt is ignored outside REQ.
  - in_rs_start is ignored outside IDLE.
- **Registered outputs**: all memory and ROB outputs are registered state or decoded from state. There is no combinational path from in_mem_* to out_rob_*.

## Timing
- Reset (asynchronous, any state):
  - FSM returns to IDLE; out_rs_ready = 1.
  - All other outputs are 0; the counter is 0.
  - An in-flight memory request is abandoned.
- Accept edge is cycle 0.
- Store with immediate grant: REQ in cycle 1, RESP (done) in cycle 2.
- Load with immediate grant and rvalid one cycle later: done in cycle 3.
- in_mem_rvalid in the same cycle as in_mem_gnt is not legal from memory and is ignored.
- out_rs_ready falls in cycle 1 and stays low until the cycle after RESP. Back-to-back stores therefore start every 3 cycles.
- Timeout with a never-granting memory: REQ is entered in cycle 1 and done is asserted in cycle TIMEOUT_CYCLES+1.
- Simultaneous timeout and gnt/rvalid in the same cycle: gnt/rvalid wins and completes normally.

## Configuration
- FU_LS_ALIGN_CHECK_EN, when defined:
  - In IDLE, an accepted LDUR/STUR with address[2:0] ≠ 0 goes straight to RESP with error = 1 and value = 0.
  - out_mem_req is never asserted for that entry.
- When undefined, no alignment check is made and misaligned addresses are forwarded to memory unchanged.

## Test plan
- Reset: hold in_rst_n = 0 mid-WAIT → out_rob_done = 0, out_mem_req = 0, out_rs_ready = 1 immediately. The next load completes normally.
- Load: start LDUR addr 0x40, dst 5; gnt in cycle 1; rvalid with rdata 0x1234 in cycle 2 → done in cycle 3 with index 5, value 0x1234, error 0.
- Store with grant stalled: STUR addr 0x80, data 0xDEAD, gnt withheld for 4 cycles → out_mem_req, out_mem_we = 1, addr and wdata are stable throughout. Done comes one cycle after gnt with value 0.
- Timeout: TIMEOUT_CYCLES = 10, gnt never asserted → done with error 1 in cycle 11. A start asserted during the wait is ignored.
- Misaligned, macro defined: LDUR addr 0x43 → out_mem_req never asserted; done in cycle 1 with error 1.
- Misaligned, macro undefined: the same LDUR is issued to memory at 0x43.
- Illegal op and stray data: non-LS op → error done in cycle 1. A stray rvalid in IDLE produces no done.
